// File: rtl/calc_pkg.sv
// Shared constants for the keypad calculator controller:
// widths, range limit, opcodes, key codes and FSM states.
`timescale 1ns/1ps
package calc_pkg;

   localparam int CALC_DIGITS = 3;
   localparam int CALC_OPW    = 11;
   localparam int CALC_RESW   = 21;
   localparam int CALC_LIMIT  = 999;

   localparam logic [1:0] OP_ADD = 2'b00;
   localparam logic [1:0] OP_SUB = 2'b01;
   localparam logic [1:0] OP_MUL = 2'b10;
   localparam logic [1:0] OP_DIV = 2'b11;

   localparam logic [4:0] KEY_ADD = 5'd10;
   localparam logic [4:0] KEY_SUB = 5'd11;
   localparam logic [4:0] KEY_MUL = 5'd12;
   localparam logic [4:0] KEY_DIV = 5'd13;
   localparam logic [4:0] KEY_EQ  = 5'd14;
   localparam logic [4:0] KEY_CLR = 5'd15;
   localparam logic [4:0] KEY_NEG = 5'd16;

   typedef enum logic [2:0] {
      ENTER_A,
      OP_WAIT,
      ENTER_B,
      COMPUTE,
      CAPTURE,
      SHOW,
      ERROR
   } state_t;

endpackage

// File: rtl/calc_operand_entry.sv
// Decimal operand accumulator: magnitude, digit count and sign.
// value is the operand as it will stand after this cycle's event.
`timescale 1ns/1ps
module calc_operand_entry
   import calc_pkg::*;
#(
   parameter int DIGITS = CALC_DIGITS,
   parameter int OPW    = CALC_OPW
)(
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  clr,
   input  logic                  start,
   input  logic                  digit_en,
   input  logic                  negate,
   input  logic [3:0]            digit,
   output logic signed [OPW-1:0] value
);

   localparam int CW = $clog2(DIGITS + 1);
   localparam logic [CW-1:0] CMAX = CW'(DIGITS);

   logic [OPW-1:0] mag;
   logic [OPW-1:0] mag_n;
   logic [OPW-1:0] dext;
   logic [CW-1:0]  cnt;
   logic [CW-1:0]  cnt_n;
   logic           neg;
   logic           neg_n;

   assign dext = {{(OPW-4){1'b0}}, digit};

   always_comb begin
      mag_n = mag;
      cnt_n = cnt;
      neg_n = neg;
      if (clr) begin
         mag_n = '0;
         cnt_n = '0;
         neg_n = 1'b0;
      end else if (start) begin
         mag_n = dext;
         cnt_n = CW'(1);
         neg_n = 1'b0;
      end else begin
         if (digit_en && cnt != CMAX) begin
            mag_n = (mag << 3) + (mag << 1) + dext;
            cnt_n = cnt + CW'(1);
         end
         if (negate)
            neg_n = ~neg;
      end
   end

   assign value = neg_n ? -$signed(mag_n) : $signed(mag_n);

   always_ff @(posedge clock) begin
      if (reset) begin
         mag <= '0;
         cnt <= '0;
         neg <= 1'b0;
      end else begin
         mag <= mag_n;
         cnt <= cnt_n;
         neg <= neg_n;
      end
   end

endmodule

// File: rtl/calc_controller.sv
// Keypad sequencer feeding the calculator ALU and display mux.
// Define CALC_CHAIN_EN to let an operator in SHOW chain on the result.
`timescale 1ns/1ps
module calc_controller
   import calc_pkg::*;
#(
   parameter int DIGITS = CALC_DIGITS,
   parameter int OPW    = CALC_OPW,
   parameter int RESW   = CALC_RESW
)(
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   key_valid,
   input  logic [4:0]             key_code,
   input  logic signed [RESW-1:0] alu_result,
   output logic signed [OPW-1:0]  regA,
   output logic signed [OPW-1:0]  regB,
   output logic [1:0]             opcode,
   output logic                   computestrobe,
   output logic signed [RESW-1:0] disp_value,
   output logic                   disp_is_result,
   output logic                   err,
   output logic                   busy
);

   state_t state;
   state_t state_n;

   logic signed [OPW-1:0]  ra_n;
   logic signed [OPW-1:0]  rb_n;
   logic [1:0]             op_n;
   logic signed [RESW-1:0] dv_n;
   logic                   dr_n;

   logic                   ent_clr;
   logic                   ent_start;
   logic                   ent_dig;
   logic                   ent_neg;
   logic signed [OPW-1:0]  ent_val;

   logic                   is_dig;
   logic                   is_op;
   logic                   is_eq;
   logic                   is_clr;
   logic                   is_neg;
   logic [1:0]             kop;

   assign is_dig = key_valid && key_code <= 5'd9;
   assign is_op  = key_valid && key_code >= KEY_ADD && key_code <= KEY_DIV;
   assign is_eq  = key_valid && key_code == KEY_EQ;
   assign is_clr = key_valid && key_code == KEY_CLR;
   assign is_neg = key_valid && key_code == KEY_NEG;
   // keys 10..13 map onto opcodes 00..11 by a 2-bit offset
   assign kop    = key_code[1:0] + 2'b10;

`ifdef CALC_CHAIN_EN
   localparam logic signed [RESW-1:0] LIM = RESW'(CALC_LIMIT);
   logic over;
   assign over = (disp_value > LIM) || (disp_value < -LIM);
`endif

   calc_operand_entry #(
      .DIGITS (DIGITS),
      .OPW    (OPW)
   ) u_entry (
      .clock    (clock),
      .reset    (reset),
      .clr      (ent_clr),
      .start    (ent_start),
      .digit_en (ent_dig),
      .negate   (ent_neg),
      .digit    (key_code[3:0]),
      .value    (ent_val)
   );

   always_comb begin
      state_n   = state;
      ra_n      = regA;
      rb_n      = regB;
      op_n      = opcode;
      dv_n      = disp_value;
      dr_n      = disp_is_result;
      ent_clr   = 1'b0;
      ent_start = 1'b0;
      ent_dig   = 1'b0;
      ent_neg   = 1'b0;
      if (is_clr) begin
         state_n = ENTER_A;
         ra_n    = '0;
         rb_n    = '0;
         op_n    = OP_ADD;
         dv_n    = '0;
         dr_n    = 1'b0;
         ent_clr = 1'b1;
      end else begin
         unique case (state)
            ENTER_A: begin
               ent_dig = is_dig;
               ent_neg = is_neg;
               if (is_dig || is_neg) begin
                  ra_n = ent_val;
                  dv_n = RESW'(ent_val);
               end else if (is_op) begin
                  op_n    = kop;
                  ent_clr = 1'b1;
                  state_n = OP_WAIT;
               end
            end
            OP_WAIT: begin
               ent_dig = is_dig;
               if (is_op) begin
                  op_n = kop;
               end else if (is_dig) begin
                  rb_n    = ent_val;
                  dv_n    = RESW'(ent_val);
                  state_n = ENTER_B;
               end
            end
            ENTER_B: begin
               ent_dig = is_dig;
               ent_neg = is_neg;
               if (is_dig || is_neg) begin
                  rb_n = ent_val;
                  dv_n = RESW'(ent_val);
               end else if (is_eq) begin
                  if (opcode == OP_DIV && regB == '0)
                     state_n = ERROR;
                  else
                     state_n = COMPUTE;
               end
            end
            COMPUTE: state_n = CAPTURE;
            CAPTURE: begin
               dv_n    = alu_result;
               dr_n    = 1'b1;
               state_n = SHOW;
            end
            SHOW: begin
               if (is_dig) begin
                  ent_start = 1'b1;
                  ra_n      = ent_val;
                  dv_n      = RESW'(ent_val);
                  dr_n      = 1'b0;
                  state_n   = ENTER_A;
               end
`ifdef CALC_CHAIN_EN
               else if (is_op) begin
                  if (over) begin
                     state_n = ERROR;
                  end else begin
                     ra_n    = OPW'(disp_value);
                     op_n    = kop;
                     dr_n    = 1'b0;
                     ent_clr = 1'b1;
                     state_n = OP_WAIT;
                  end
               end
`endif
            end
            ERROR: state_n = ERROR;
            default: state_n = ENTER_A;
         endcase
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state          <= ENTER_A;
         regA           <= '0;
         regB           <= '0;
         opcode         <= OP_ADD;
         disp_value     <= '0;
         disp_is_result <= 1'b0;
      end else begin
         state          <= state_n;
         regA           <= ra_n;
         regB           <= rb_n;
         opcode         <= op_n;
         disp_value     <= dv_n;
         disp_is_result <= dr_n;
      end
   end

   assign computestrobe = state == COMPUTE;
   assign busy          = state == COMPUTE || state == CAPTURE;
   assign err           = state == ERROR;

endmodule

// File: tb/tb_calc_controller.sv
// Scoreboard bench for calc_controller with a registered ALU model.
// Chain-mode cases are selected by CALC_CHAIN_EN.
`timescale 1ns/1ps
module tb_calc_controller;
   import calc_pkg::*;

   logic                clock = 1'b0;
   logic                reset = 1'b1;
   logic                key_valid = 1'b0;
   logic [4:0]          key_code = 5'd0;
   logic signed [20:0]  alu_result;
   logic signed [10:0]  regA;
   logic signed [10:0]  regB;
   logic [1:0]          opcode;
   logic                computestrobe;
   logic signed [20:0]  disp_value;
   logic                disp_is_result;
   logic                err;
   logic                busy;

   calc_controller dut (
      .clock          (clock),
      .reset          (reset),
      .key_valid      (key_valid),
      .key_code       (key_code),
      .alu_result     (alu_result),
      .regA           (regA),
      .regB           (regB),
      .opcode         (opcode),
      .computestrobe  (computestrobe),
      .disp_value     (disp_value),
      .disp_is_result (disp_is_result),
      .err            (err),
      .busy           (busy)
   );

   always #5 clock = ~clock;

   logic signed [20:0] xa;
   logic signed [20:0] xb;
   assign xa = 21'(regA);
   assign xb = 21'(regB);

   always @(posedge clock) begin
      if (reset)
         alu_result <= '0;
      else if (computestrobe)
         case (opcode)
            2'b00: alu_result <= xa + xb;
            2'b01: alu_result <= xa - xb;
            2'b10: alu_result <= xa * xb;
            default: alu_result <= (xb != 0) ? xa / xb : '0;
         endcase
   end

   typedef struct {
      logic signed [10:0] a;
      logic signed [10:0] b;
      logic [1:0]         op;
      logic signed [20:0] res;
      bit                 chk;
   } exp_t;

   exp_t sbq[$];
   exp_t cur;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   pend = 0;

   task automatic check(input string tag,
                        input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic push(input int a, input int b, input int op,
                       input int res, input bit chk);
      exp_t e;
      e.a   = 11'(a);
      e.b   = 11'(b);
      e.op  = 2'(op);
      e.res = 21'(res);
      e.chk = chk;
      sbq.push_back(e);
   endtask

   task automatic press(input logic [4:0] k);
      key_valid = 1'b1;
      key_code  = k;
      @(negedge clock);
      key_valid = 1'b0;
      key_code  = 5'd0;
   endtask

   task automatic wait_res;
      repeat (2) @(negedge clock);
   endtask

   always @(negedge clock) begin
      if (computestrobe) begin
         if (sbq.size() == 0) begin
            check("spurious_strobe", computestrobe, 0);
         end else begin
            cur = sbq.pop_front();
            check("strobe_regA", regA, cur.a);
            check("strobe_regB", regB, cur.b);
            check("strobe_opcode", opcode, cur.op);
            check("strobe_busy", busy, 1);
            pend = 2;
         end
      end else if (pend != 0) begin
         pend--;
         if (pend == 0 && cur.chk) begin
            check("res_value", disp_value, cur.res);
            check("res_flag", disp_is_result, 1);
         end
      end
   end

   initial begin
      repeat (2) @(negedge clock);
      check("rst_regA", regA, 0);
      check("rst_regB", regB, 0);
      check("rst_opcode", opcode, 0);
      check("rst_disp", disp_value, 0);
      check("rst_flag", disp_is_result, 0);
      check("rst_err", err, 0);
      check("rst_busy", busy, 0);
      // reset beats a simultaneous key
      key_valid = 1'b1;
      key_code  = 5'd8;
      @(negedge clock);
      key_valid = 1'b0;
      check("rst_prio", regA, 0);
      reset = 1'b0;
      @(negedge clock);

      press(5'd1); press(5'd2); press(5'd3);
      check("a_123", regA, 123);
      check("disp_a", disp_value, 123);
      press(KEY_MUL);
      check("op_mul", opcode, 2);
      press(5'd4); press(5'd5);
      check("b_45", regB, 45);
      push(123, 45, 2, 5535, 1);
      press(KEY_EQ);
      wait_res();
`ifndef CALC_CHAIN_EN
      press(KEY_ADD);
      check("nochain_disp", disp_value, 5535);
      check("nochain_flag", disp_is_result, 1);
      check("nochain_op", opcode, 2);
`endif

      press(5'd7);
      check("show_dig_a", regA, 7);
      check("show_dig_flag", disp_is_result, 0);
      press(KEY_NEG);
      check("neg_a", regA, -7);
      check("neg_disp", disp_value, -7);
      press(KEY_SUB);
      check("op_sub", opcode, 1);
      press(5'd9);
      push(-7, 9, 1, -16, 1);
      press(KEY_EQ);
      wait_res();

      press(KEY_CLR);
      press(5'd1); press(5'd2); press(5'd3); press(5'd4);
      check("four_digits", regA, 123);
      press(KEY_CLR);
      press(5'd0); press(5'd0); press(5'd7); press(5'd8);
      check("lead_zero", regA, 7);

      press(KEY_CLR);
      press(5'd5); press(KEY_DIV); press(5'd0); press(KEY_EQ);
      check("div0_err", err, 1);
      check("div0_busy", busy, 0);
      press(5'd3);
      check("err_sticky", err, 1);
      press(KEY_CLR);
      check("clr_err", err, 0);
      check("clr_regA", regA, 0);
      check("clr_regB", regB, 0);
      check("clr_op", opcode, 0);
      check("clr_disp", disp_value, 0);

      press(5'd6); press(KEY_EQ); press(KEY_ADD); press(KEY_MUL);
      check("op_replace", opcode, 2);
      press(5'd7);
      push(6, 7, 2, 42, 1);
      press(KEY_EQ);
      wait_res();

      press(KEY_CLR);
      press(5'd3); press(KEY_ADD); press(5'd4); press(KEY_NEG);
      check("neg_b", regB, -4);
      push(3, -4, 0, -1, 1);
      press(KEY_EQ);
      wait_res();

      press(KEY_CLR);
      press(5'd2); press(KEY_SUB); press(5'd8);
      push(2, 8, 1, -6, 1);
      press(KEY_EQ);
      press(5'd5);
      press(5'd9);
      check("drop_flag", disp_is_result, 1);
      check("drop_disp", disp_value, -6);
      check("drop_regA", regA, 2);
      check("drop_regB", regB, 8);

      press(KEY_CLR);
      press(5'd4); press(KEY_ADD); press(5'd4);
      push(4, 4, 0, 8, 0);
      press(KEY_EQ);
      @(negedge clock);
      check("capture_busy", busy, 1);
      reset = 1'b1;
      @(negedge clock);
      reset = 1'b0;
      check("rstcap_disp", disp_value, 0);
      check("rstcap_flag", disp_is_result, 0);
      check("rstcap_busy", busy, 0);
      check("rstcap_regA", regA, 0);
      repeat (5) @(negedge clock);

`ifdef CALC_CHAIN_EN
      press(5'd1); press(5'd2); press(KEY_ADD); press(5'd3);
      push(12, 3, 0, 15, 1);
      press(KEY_EQ);
      wait_res();
      press(KEY_MUL);
      check("chain_regA", regA, 15);
      press(5'd2);
      push(15, 2, 2, 30, 1);
      press(KEY_EQ);
      wait_res();
      press(KEY_CLR);
      press(5'd9); press(5'd9); press(5'd9); press(KEY_MUL);
      press(5'd9); press(5'd9); press(5'd9);
      push(999, 999, 2, 998001, 1);
      press(KEY_EQ);
      wait_res();
      press(KEY_ADD);
      check("chain_over_err", err, 1);
`endif

      repeat (4) @(negedge clock);
      check("missing_strobe", sbq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/calc_controller.md
# calc_controller

Keypad-driven sequencer for the calculator datapath. It accumulates two signed decimal operands (±999) and an operator from single-cycle key events, then drives the ALU operand, opcode and compute-strobe inputs. It captures the ALU result at the correct cycle and presents the value to display, with error and busy status. It sits between the keypad decoder and the ALU/display mux.

## Interface
- `DIGITS`, default 3: maximum decimal digits per operand.
- `OPW`, default 11: signed operand width (±999).
- `RESW`, default 21: signed result width (±998001).
- `clock` in 1: the single clock; all state updates on the posedge.
- `reset` in 1: synchronous, active-high.
- `key_valid` in 1: one-cycle key event strobe.
- `key_code` in 5: 0–9 digit, 10 add, 11 subtract, 12 multiply, 13 divide, 14 equals, 15 clear, 16 negate; 17–31 ignored.
- `alu_result` in RESW: ALU registered result.
- `regA`, `regB` out OPW: signed operands to the ALU, registered.
- `opcode` out 2: 00 add, 01 subtract, 10 multiply, 11 divide.
- `computestrobe` out 1: one-cycle ALU compute enable.
- `disp_value` out RESW: signed value to display (operand being entered, or the result).
- `disp_is_result` out 1: `disp_value` holds a captured result.
- `err` out 1: sticky error.
- `busy` out 1: high in COMPUTE and CAPTURE.

## Operation
- States:
  - ENTER_A
  - OP_WAIT
  - ENTER_B
  - COMPUTE
  - CAPTURE
  - SHOW
  - ERROR
- Reset and clear key (any state) both go to ENTER_A with every output 0, magnitude 0, digit count 0 and sign positive.
- Digit accumulation: magnitude = magnitude*10 + d, count+1. The digit is ignored when count == DIGITS. Leading zeros count as digits.
- Negate: toggles the sign of the operand currently being entered. Honoured only in ENTER_A/ENTER_B. The operand equals −magnitude when the sign is negative; −0 equals 0.
- ENTER_A:
  - Digit or negate updates `regA`.
  - Operator latches `opcode` → OP_WAIT, even with zero digits (A = 0).
  - Equals is ignored.
- OP_WAIT:
  - Operator replaces `opcode`.
  - Digit → ENTER_B, `regB` = that digit.
  - Equals and negate are ignored.
- ENTER_B:
  - Digit or negate updates `regB`.
  - Equals → COMPUTE, except divide with `regB` == 0 → ERROR with no strobe.
  - Operator is ignored.
- COMPUTE: `computestrobe` = 1 for exactly this cycle → CAPTURE.
- CAPTURE: samples `alu_result` into `disp_value`, sets `disp_is_result` → SHOW.
- SHOW:
  - A digit starts a new calculation: ENTER_A with A = that digit, `disp_is_result` = 0.
  - Operator behaviour per Configuration.
  - Equals is ignored.
- ERROR: `err` = 1. Only clear or reset exits.
- Outside SHOW, `disp_value` mirrors the operand being entered, sign-extended to RESW.
- Keys arriving in COMPUTE/CAPTURE are dropped and not queued.

## Timing
- One key is accepted per cycle. Its effect is visible on registered outputs the following cycle.
- Equals accepted at edge t: `computestrobe` high during cycle t+1. The ALU registers the result at the end of t+1. CAPTURE samples during t+2. `disp_value` and `disp_is_result` update at t+3.
- `busy` is high in exactly cycles t+1 and t+2.
- `regA`, `regB` and `opcode` remain stable from the strobe cycle through CAPTURE.
- Reset or clear asserted during COMPUTE/CAPTURE wins. The result is discarded and outputs read 0 on the next cycle.
- Reset has priority over `key_valid` in the same cycle.

## Configuration
- `CALC_CHAIN_EN` defined: an operator key in SHOW loads A = captured result and latches the operator → OP_WAIT. If |result| > 999 it goes to ERROR instead.
- `CALC_CHAIN_EN` undefined: an operator key in SHOW is ignored.

## Structure
- Shared package `calc_pkg`:
  - opcode constants
  - key-code constants
  - state enumeration
  - `OPW`/`RESW` widths
  - the 999 range limit
- Sub-module `calc_operand_entry`: holds the digit accumulator, digit counter and sign. It has load/clear/negate/digit inputs and a signed OPW output. The controller instantiates it once and shares it between A and B, freezing A at the operator key.

## Test plan
- 1,2,3,×,4,5,= → a single strobe with `regA`=123, `regB`=45, `opcode`=10. `disp_value`=5535 and `disp_is_result`=1 two cycles after the strobe.
- 7,neg,−,9,= → `regA`=−7, `regB`=9, `opcode`=01, `disp_value`=−16. 1,2,3,4 entry → `regA`=123, fourth digit ignored.
- 5,÷,0,= → `err`=1, no `computestrobe`. Clear → `err`=0 and all outputs 0.
- Keys sent during COMPUTE/CAPTURE are dropped. Reset asserted in CAPTURE → `disp_value`=0 and `disp_is_result`=0 on the next cycle, and no further strobe.
- With `CALC_CHAIN_EN`: 1,2,+,3,= then ×,2,= → second strobe with `regA`=15, result 30. 9,9,9,×,9,9,9,= → 998001, then + → `err`=1.
- Without `CALC_CHAIN_EN`: after a result, + is ignored (state SHOW holds, `disp_value` unchanged).
